// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: SCAN-ordered call latch and target selection for a single car, with door dwell.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int DWELL_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [NUM_FLOORS-1:0] present_floor,
  output logic [NUM_FLOORS-1:0] target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  busy
);
  localparam int FW = NUM_FLOORS > 1 ? $clog2(NUM_FLOORS) : 1;
  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;
  state_t                  state_q;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d, target_q, cur_oh, sel_oh, clr;
  logic [FW-1:0]           cur, up_idx, dn_idx, sel_idx;
  logic                    up_f, dn_f, has_cur, sel_f, rev, arrive, dir_q, door_q, busy_q;
  logic [3:0]              cnt_q;
  always_comb begin
    cur = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) if (present_floor[i]) cur = FW'(i);
    cur_oh = '0;
    cur_oh[cur] = 1'b1;
    up_f = 1'b0;
    up_idx = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending_q[i] && FW'(i) > cur) begin
        up_f = 1'b1;
        up_idx = FW'(i);
      end
    dn_f = 1'b0;
    dn_idx = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending_q[i] && FW'(i) < cur) begin
        dn_f = 1'b1;
        dn_idx = FW'(i);
      end
    has_cur = pending_q[cur];
    sel_f   = up_f | dn_f | has_cur;
    sel_idx = dir_q ? (up_f ? up_idx : dn_f ? dn_idx : cur)
                    : (dn_f ? dn_idx : up_f ? up_idx : cur);
    rev     = dir_q ? (!up_f && dn_f) : (!dn_f && up_f);
    sel_oh  = '0;
    sel_oh[sel_idx] = 1'b1;
    sel_oh  = sel_f ? sel_oh : present_floor;
    arrive  = has_cur && (state_q == IDLE || (state_q == MOVING && present_floor == target_q));
    // While the door is open the current floor is being served, so its button never latches.
    clr       = (arrive || state_q == DOOR) ? cur_oh : '0;
    pending_d = (pending_q | call_btn) & ~clr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= NUM_FLOORS'(1);
      dir_q     <= 1'b1;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE, MOVING: begin
          if (rev) dir_q <= ~dir_q;
          if (arrive) begin
            state_q  <= DOOR;
            target_q <= present_floor;
            cnt_q    <= 4'(DWELL_TICKS);
            door_q   <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= |pending_q ? MOVING : IDLE;
            target_q <= sel_oh;
            busy_q   <= |pending_q;
          end
        end
        DOOR: begin
          if (call_btn[cur]) cnt_q <= 4'(DWELL_TICKS);
          else if (tick) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= IDLE;
              door_q  <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign target_floor = target_q;
  assign pending      = pending_q;
  assign dir_up       = dir_q;
  assign door_open    = door_q;
  assign busy         = busy_q;
endmodule
